// File: rtl/pb_event_arbiter_pkg.sv
// Purpose: shared types for the pushbutton event arbiter (button FSM states, event record).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pb_pkg;

  // Widest button index carried in an event record (up to 8 buttons).
  localparam int ID_MAX_W = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    LONG_SENT = 2'd2
  } btn_state_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic                is_long;
  } pb_ev_t;

  localparam logic EV_SHORT = 1'b0;
  localparam logic EV_LONG  = 1'b1;

endpackage

// File: rtl/pb_event_arbiter_if.sv
// Purpose: valid/ready event channel from the arbiter to the gesture mode controller.
// Latency: n/a (wires only).
// Backpressure: producer holds ev_id/ev_long stable while ev_valid is high and ev_ready is low.
interface pb_event_arbiter_if #(
  parameter int N_BTN = 4
);
  localparam int ID_W = $clog2(N_BTN);

  logic            ev_valid;
  logic            ev_ready;
  logic [ID_W-1:0] ev_id;
  logic            ev_long;

  modport master (output ev_valid, output ev_id, output ev_long, input ev_ready);
  modport slave  (input ev_valid, input ev_id, input ev_long, output ev_ready);

endinterface

// File: rtl/pb_event_arbiter_fifo.sv
// Purpose: small synchronous FIFO with occupancy count; head is shown combinationally.
// Latency: a push is visible at the head one cycle later; pop is ignored when empty.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module pb_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = cnt_q;
  // When empty the outputs keep showing the last entry that left the FIFO.
  assign pop_dat = empty ? last_q : mem[rd_q];

  // Storage array; no reset needed since reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_dat;
  end

  // Pointers, occupancy and last-popped entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) begin
        rd_q   <= rd_q + AW'(1);
        last_q <= mem[rd_q];
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/pb_event_arbiter.sv
// Purpose: classify debounced button presses as SHORT/LONG and arbitrate them round-robin into an event FIFO.
// Latency: release sampled at edge k -> pending at k -> pushed at k+1 -> ev_valid after k+1.
// Backpressure: one pending slot per button behind the FIFO; a second event on an occupied slot is dropped and sets sticky overflow.
module pb_event_arbiter
  import pb_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int LONG_CYC   = 100_000_000,
  parameter int CNT_W      = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_BTN-1:0]            pb_level,
  pb_event_arbiter_if.master          ev,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int ID_W = $clog2(N_BTN);

  logic             first_q;
  logic [N_BTN-1:0] prev_q;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] ev_raise;
  logic [N_BTN-1:0] ev_type;
  logic [N_BTN-1:0] pend_q;
  logic [N_BTN-1:0] ptype_q;
  logic [N_BTN-1:0] gnt;
  logic [ID_W-1:0]  rr_q;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_vld;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  pb_ev_t           push_ev;
  pb_ev_t           head_ev;

  // Level history; the first cycle out of reset loads the live level so a button held through reset needs a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= '0;
      first_q <= 1'b1;
    end else begin
      prev_q  <= pb_level;
      first_q <= 1'b0;
    end
  end

  assign rise = pb_level & ~prev_q & {N_BTN{~first_q}};

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_state_t       st_q;
    btn_state_t       st_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             raise;
    logic             typ;

    // Per-button state and hold counter.
    always_ff @(posedge clk) begin
      if (reset) begin
        st_q  <= IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    // Press classification; a release always wins over reaching the LONG threshold.
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      raise = 1'b0;
      typ   = EV_SHORT;
      unique case (st_q)
        IDLE: begin
          if (rise[g]) begin
            st_d  = HELD;
            cnt_d = '0;
          end
        end
        HELD: begin
          if (!pb_level[g]) begin
            raise = 1'b1;
            typ   = EV_SHORT;
            st_d  = IDLE;
          end else if (cnt_q == CNT_W'(LONG_CYC - 1)) begin
            raise = 1'b1;
            typ   = EV_LONG;
            st_d  = LONG_SENT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LONG_SENT: begin
          if (!pb_level[g]) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end

    assign ev_raise[g] = raise;
    assign ev_type[g]  = typ;
  end

  assign pop = ~fifo_empty & ev.ev_ready;

  // Round-robin pick of one pending button, starting at rr, only when the FIFO can take it.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    if (!fifo_full || pop) begin
      for (int k = 0; k < N_BTN; k++) begin
        idx = (int'(rr_q) + k) % N_BTN;
        if (!gnt_vld && pend_q[idx]) begin
          gnt_vld  = 1'b1;
          gnt_id   = ID_W'(idx);
          gnt[idx] = 1'b1;
        end
      end
    end
  end

  // Pending slots, sticky overflow and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= '0;
      ptype_q  <= '0;
      rr_q     <= '0;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (ev_raise[i]) begin
          // A slot granted this cycle is free to take the new event.
          if (pend_q[i] && !gnt[i]) begin
            overflow <= 1'b1;
          end else begin
            pend_q[i]  <= 1'b1;
            ptype_q[i] <= ev_type[i];
          end
        end else if (gnt[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
      if (gnt_vld) rr_q <= (gnt_id == ID_W'(N_BTN - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  assign push_ev.id      = ID_MAX_W'(gnt_id);
  assign push_ev.is_long = |(ptype_q & gnt);

  pb_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pb_ev_t))
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (gnt_vld),
    .push_dat (push_ev),
    .pop      (pop),
    .pop_dat  (head_ev),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  assign ev.ev_valid = ~fifo_empty;
  assign ev.ev_id    = ID_W'(head_ev.id);
  assign ev.ev_long  = head_ev.is_long;

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Purpose: randomized and directed stimulus for pb_event_arbiter against a press-duration reference model.
// Latency: model is evaluated at every rising edge, outputs compared at the following falling edge.
// Backpressure: ev_ready is driven both directed and randomly to exercise full FIFO and overflow.
module tb_pb_event_arbiter;

  localparam int N_BTN      = 4;
  localparam int LONG_CYC   = 8;
  localparam int CNT_W      = 4;
  localparam int FIFO_DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_BTN-1:0] pb_level = '0;
  logic             overflow;
  logic [2:0]       fifo_count;

  pb_event_arbiter_if #(.N_BTN(N_BTN)) ev_if ();

  pb_event_arbiter #(
    .N_BTN      (N_BTN),
    .LONG_CYC   (LONG_CYC),
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pb_level   (pb_level),
    .ev         (ev_if),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: press duration in sampled-high cycles, pending slots, FIFO as a queue.
  bit m_pend [N_BTN];
  bit m_ptype[N_BTN];
  bit m_inpress[N_BTN];
  bit m_longdone[N_BTN];
  bit m_lastlow[N_BTN];
  int m_hold[N_BTN];
  int m_rr;
  bit m_ovf;
  int m_q[$];
  int m_last;
  int seen[$];

  function automatic int enc(int id, int lng);
    return id * 2 + lng;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    bit pop;
    int gnt;
    bit ev[N_BTN];
    bit typ[N_BTN];
    if (reset) begin
      for (int i = 0; i < N_BTN; i++) begin
        m_pend[i] = 0; m_ptype[i] = 0; m_inpress[i] = 0;
        m_longdone[i] = 0; m_lastlow[i] = 0; m_hold[i] = 0;
      end
      m_rr = 0; m_ovf = 0; m_last = 0;
      m_q.delete();
      return;
    end
    pop = (m_q.size() > 0) && ev_if.ev_ready;
    gnt = -1;
    if (m_q.size() < FIFO_DEPTH || pop) begin
      for (int k = 0; k < N_BTN; k++) begin
        int b;
        b = (m_rr + k) % N_BTN;
        if (gnt < 0 && m_pend[b]) gnt = b;
      end
    end
    for (int i = 0; i < N_BTN; i++) begin
      ev[i] = 0; typ[i] = 0;
      if (pb_level[i]) begin
        if (m_inpress[i]) begin
          m_hold[i]++;
          if (!m_longdone[i] && m_hold[i] == LONG_CYC + 1) begin
            ev[i] = 1; typ[i] = 1; m_longdone[i] = 1;
          end
        end else if (m_lastlow[i]) begin
          m_inpress[i] = 1; m_hold[i] = 1; m_longdone[i] = 0;
        end
      end else begin
        if (m_inpress[i] && !m_longdone[i]) begin
          ev[i] = 1; typ[i] = 0;
        end
        m_inpress[i] = 0;
      end
      m_lastlow[i] = !pb_level[i];
    end
    if (pop) m_last = m_q.pop_front();
    if (gnt >= 0) begin
      m_q.push_back(enc(gnt, m_ptype[gnt]));
      m_pend[gnt] = 0;
      m_rr = (gnt + 1) % N_BTN;
    end
    for (int i = 0; i < N_BTN; i++) begin
      if (ev[i]) begin
        if (m_pend[i]) m_ovf = 1;
        else begin m_pend[i] = 1; m_ptype[i] = typ[i]; end
      end
    end
  endtask

  task automatic compare();
    int exp_head;
    exp_head = (m_q.size() > 0) ? m_q[0] : m_last;
    chk("ev_valid",   ev_if.ev_valid, m_q.size() > 0);
    chk("ev_id",      ev_if.ev_id, exp_head / 2);
    chk("ev_long",    ev_if.ev_long, exp_head % 2);
    chk("fifo_count", fifo_count, m_q.size());
    chk("overflow",   overflow, m_ovf);
  endtask

  task automatic step();
    if (ev_if.ev_valid === 1'b1 && ev_if.ev_ready === 1'b1)
      seen.push_back(enc(ev_if.ev_id, ev_if.ev_long));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    cyc++;
  endtask

  task automatic idle(input int n);
    pb_level = '0;
    repeat (n) step();
  endtask

  task automatic press(input logic [N_BTN-1:0] mask, input int n);
    pb_level = mask;
    repeat (n) step();
    pb_level = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    ev_if.ev_ready = 1'b1;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    idle(2);

    // Short press on button 2.
    seen.delete();
    press(4'b0100, 3); idle(6);
    chk("short_cnt", seen.size(), 1);
    if (seen.size() > 0) chk("short_ev", seen[0], enc(2, 0));

    // Long press, then release at the threshold boundary on either side.
    seen.delete();
    press(4'b0010, 20); idle(5);
    chk("long_cnt", seen.size(), 1);
    if (seen.size() > 0) chk("long_ev", seen[0], enc(1, 1));
    seen.delete();
    press(4'b0010, LONG_CYC); idle(5);
    press(4'b0010, LONG_CYC + 1); idle(5);
    chk("edge_cnt", seen.size(), 2);
    if (seen.size() > 1) begin
      chk("edge_short", seen[0], enc(1, 0));
      chk("edge_long",  seen[1], enc(1, 1));
    end

    // Contention from rr=0, then from rr=1.
    do_reset(); idle(2);
    seen.delete();
    press(4'b1001, 2); idle(6);
    chk("rr0_cnt", seen.size(), 2);
    if (seen.size() > 1) begin
      chk("rr0_first",  seen[0], enc(0, 0));
      chk("rr0_second", seen[1], enc(3, 0));
    end
    press(4'b0001, 2); idle(5);
    seen.delete();
    press(4'b1001, 2); idle(6);
    chk("rr1_cnt", seen.size(), 2);
    if (seen.size() > 1) begin
      chk("rr1_first",  seen[0], enc(3, 0));
      chk("rr1_second", seen[1], enc(0, 0));
    end

    // Backpressure: fill the FIFO, park one pending, then overflow it.
    ev_if.ev_ready = 1'b0;
    for (int b = 0; b < N_BTN; b++) begin
      press(4'b0001 << b, 2); idle(2);
    end
    press(4'b0001, 2); idle(2);
    chk("bp_full", fifo_count, FIFO_DEPTH);
    chk("bp_no_ovf", overflow, 0);
    press(4'b0001, 2); idle(2);
    chk("bp_ovf", overflow, 1);
    seen.delete();
    ev_if.ev_ready = 1'b1;
    step();
    chk("pushpop_full", fifo_count, FIFO_DEPTH);
    idle(8);
    chk("drain_cnt", seen.size(), 5);
    if (seen.size() > 4) begin
      for (int b = 0; b < N_BTN; b++) chk("drain_order", seen[b], enc(b, 0));
      chk("drain_last", seen[4], enc(0, 0));
    end

    // Reset while button 0 is held: no event until a fresh press.
    pb_level = 4'b0001;
    repeat (2) step();
    reset = 1'b1; step(); reset = 1'b0;
    seen.delete();
    repeat (4) step();
    idle(5);
    chk("rst_hold_none", seen.size(), 0);
    press(4'b0001, 3); idle(5);
    chk("rst_fresh_cnt", seen.size(), 1);
    if (seen.size() > 0) chk("rst_fresh_ev", seen[0], enc(0, 0));

    // Randomized phase with varying consumer throughput.
    for (int seg = 0; seg < 20; seg++) begin
      int rdy_pct;
      rdy_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
      repeat (200) begin
        for (int b = 0; b < N_BTN; b++)
          if ($urandom_range(0, 9) == 0) pb_level[b] = ~pb_level[b];
        ev_if.ev_ready = ($urandom_range(0, 99) < rdy_pct);
        reset = ($urandom_range(0, 799) == 0);
        step();
      end
    end
    reset = 1'b0;
    ev_if.ev_ready = 1'b1;
    idle(30);
    chk("final_empty", fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
